// File: rtl/axi_fifo_pkg.sv
// Shared constants and helpers for the AXI-style handshake FIFO.
// Pointer wrap is an explicit compare against DEPTH-1, so non-power-of-two depths work.
package axi_fifo_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 16;

   // Occupancy needs to represent 0..DEPTH inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/axi_hs_fifo_if.sv
// Valid/ready handshake bundle for the FIFO write and read sides.
// master = producer/consumer side, slave = FIFO side.
interface axi_hs_fifo_if import axi_fifo_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/axi_fifo_ptr.sv
// Circular FIFO pointer: advances on inc, wraps from DEPTH-1 to 0, clr has priority.
module axi_fifo_ptr import axi_fifo_pkg::*; #(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int PW    = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          clr,
   output logic [PW-1:0] ptr
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= PW'(ptr_next(32'(ptr), 32'(DEPTH)));
   end

endmodule

// File: rtl/axi_hs_fifo.sv
// Show-ahead synchronous FIFO with valid/ready handshake, flush and threshold flags.
// Define AXI_HS_FIFO_ERR_EN to build the sticky overflow flag; otherwise ovf_err is tied low.
module axi_hs_fifo import axi_fifo_pkg::*; #(
   parameter  int WIDTH    = DEFAULT_WIDTH,
   parameter  int DEPTH    = DEFAULT_DEPTH,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 2,
   localparam int CW       = cnt_w(DEPTH),
   localparam int PW       = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   axi_hs_fifo_if.slave  bus,
   output logic [CW-1:0] count,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          ovf_err
);

   if (DEPTH < 2 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_cfg
      $fatal(1, "axi_hs_fifo: illegal configuration DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
             DEPTH, AF_LEVEL, AE_LEVEL);
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             wr_adv;
   logic             rd_adv;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_data  = mem[rptr];

   assign push   = bus.in_valid && bus.in_ready;
   assign pop    = bus.out_valid && bus.out_ready;
   assign wr_adv = push && !flush;
   assign rd_adv = pop && !flush;

   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   // NOTE: the storage array is deliberately not reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_adv)
         mem[wptr] <= bus.in_data;
   end

   axi_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_adv),
      .clr   (flush),
      .ptr   (wptr)
   );

   axi_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
      .clk   (clk),
      .reset (reset),
      .inc   (rd_adv),
      .clr   (flush),
      .ptr   (rptr)
   );

   // Simultaneous push and pop leaves occupancy unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (flush)
         count <= '0;
      else if (push && !pop)
         count <= count + CW'(1);
      else if (pop && !push)
         count <= count - CW'(1);
   end

`ifdef AXI_HS_FIFO_ERR_EN
   // Any write attempt while full is an overflow, whether or not a pop happens that cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf_err <= 1'b0;
      else if (flush)
         ovf_err <= 1'b0;
      else if (bus.in_valid && full)
         ovf_err <= 1'b1;
   end
`else
   assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_hs_fifo.sv
// Scoreboard bench for axi_hs_fifo at WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
// Honors AXI_HS_FIFO_ERR_EN for the expected overflow flag.
module tb_axi_hs_fifo;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 5;
   localparam int AF_LEVEL = 4;
   localparam int AE_LEVEL = 1;
`ifdef AXI_HS_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       flush;
   logic [2:0] count;
   logic       almost_full;
   logic       almost_empty;
   logic       ovf_err;

   axi_hs_fifo_if #(.WIDTH(WIDTH)) bus ();

   axi_hs_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .bus          (bus),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .ovf_err      (ovf_err)
   );

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   bit         exp_ovf  = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive inputs just after a rising edge and let combinational outputs settle.
   task automatic drive(input bit iv, input logic [7:0] d, input bit ordy);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
   endtask

   // Advance one clock and update the reference queue from what the FIFO should accept.
   task automatic tick();
      bit         pu;
      bit         po;
      bit         was_full;
      logic [7:0] d;
      was_full = (exp_q.size() == DEPTH);
      pu = bus.in_valid && !was_full;
      po = bus.out_ready && (exp_q.size() != 0);
      d  = bus.in_data;
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
      end else begin
         if (po) void'(exp_q.pop_front());
         if (pu) exp_q.push_back(d);
      end
      if (ERR_EN) begin
         if (flush) exp_ovf = 1'b0;
         else if (bus.in_valid && was_full) exp_ovf = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++;
      if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
      checks++;
      if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
      checks++;
      if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf_err: got %b expected 0", ovf_err); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'h11 + 8'(i), 1'b0);
         checks++;
         if (count !== 3'(i)) begin failures++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
         checks++;
         if (almost_full !== (i >= AF_LEVEL)) begin failures++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full, (i >= AF_LEVEL)); end
         checks++;
         if (almost_empty !== (i <= AE_LEVEL)) begin failures++; $display("FAIL fill_almost_empty[%0d]: got %b expected %b", i, almost_empty, (i <= AE_LEVEL)); end
         checks++;
         if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd5) begin failures++; $display("FAIL full_count: got %0d expected 5", count); end
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %b expected 0", bus.in_ready); end
      checks++;
      if (almost_full !== 1'b1) begin failures++; $display("FAIL full_almost_full: got %b expected 1", almost_full); end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         checks++;
         if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || bus.out_data !== exp_q[0] || bus.out_data !== 8'h11 + 8'(i)) begin
            failures++;
            $display("FAIL drain_data[%0d]: got valid=%b data=%h expected data=%h", i, bus.out_valid, bus.out_data, 8'h11 + 8'(i));
         end
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL drained_empty: got count=%0d valid=%b expected 0/0", count, bus.out_valid); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'h21 + 8'(i), 1'b0);
         tick();
      end
      drive(1'b1, 8'h26, 1'b1);
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL simul_in_ready: got %b expected 0", bus.in_ready); end
      checks++;
      if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin failures++; $display("FAIL simul_head: got %h expected %h", bus.out_data, exp_q[0]); end
      tick();
      drive(1'b1, 8'h26, 1'b0);
      checks++;
      if (count !== 3'd4) begin failures++; $display("FAIL simul_count: got %0d expected 4", count); end
      checks++;
      if (ovf_err !== exp_ovf) begin failures++; $display("FAIL simul_ovf_err: got %b expected %b", ovf_err, exp_ovf); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL retry_in_ready: got %b expected 1", bus.in_ready); end
      tick();
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd5) begin failures++; $display("FAIL retry_count: got %0d expected 5", count); end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         checks++;
         if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin failures++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, bus.out_data, exp_q[0]); end
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (ovf_err !== exp_ovf) begin failures++; $display("FAIL ovf_sticky: got %b expected %b", ovf_err, exp_ovf); end
   endtask

   task automatic test_stream_wrap();
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, 8'h40 + 8'(k), 1'b1);
         if (k == 0) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid: got %b expected 0", bus.out_valid); end
         end else begin
            checks++;
            if (count !== 3'd1) begin failures++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, count); end
            checks++;
            if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin failures++; $display("FAIL stream_data[%0d]: got %h expected %h", k, bus.out_data, exp_q[0]); end
         end
         tick();
      end
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (exp_q.size() == 0 || bus.out_data !== exp_q[0] || bus.out_data !== 8'h4B) begin failures++; $display("FAIL stream_last: got %h expected 4b", bus.out_data); end
      tick();
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL stream_end_count: got %0d expected 0", count); end
   endtask

   task automatic test_no_bypass();
      drive(1'b1, 8'hA5, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bypass_same_cycle: got valid=%b expected 0", bus.out_valid); end
      tick();
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
         failures++;
         $display("FAIL bypass_next_cycle: got valid=%b data=%h expected 1/a5", bus.out_valid, bus.out_data);
      end
      drive(1'b0, 8'h00, 1'b1);
      tick();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h61 + 8'(i), 1'b0);
         tick();
      end
      drive(1'b1, 8'h64, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", count); end
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
      checks++;
      if (ovf_err !== exp_ovf) begin failures++; $display("FAIL flush_ovf_err: got %b expected %b", ovf_err, exp_ovf); end
      drive(1'b1, 8'h70, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (count !== 3'd1 || exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
         failures++;
         $display("FAIL flush_after_push: got count=%0d data=%h expected 1/70", count, bus.out_data);
      end
      tick();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h51 + 8'(i), 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd3) begin failures++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
      #2;
      reset = 1'b1;
      exp_q.delete();
      exp_ovf = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL async_count: got %0d expected 0", count); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL async_in_ready: got %b expected 1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid: got %b expected 0", bus.out_valid); end
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 8'h81, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (count !== 3'd1 || exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
         failures++;
         $display("FAIL post_reset_first: got count=%0d data=%h expected 1/81", count, bus.out_data);
      end
      tick();
   endtask

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_fill_drain();
      test_full_simul();
      test_stream_wrap();
      test_no_bypass();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_hs_fifo.md
AXI_HS_FIFO -- requirements
Module: axi_hs_fifo

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, >=1.
REQ-002 Parameter DEPTH, default 16: entry count, >=2, non-power-of-two allowed.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  synchronous clear of contents and error flag.
REQ-008 in_valid  in  1  write request.
REQ-009 in_data  in  WIDTH  write payload.
REQ-010 in_ready  out  1  space available.
REQ-011 out_valid  out  1  data available.
REQ-012 out_data  out  WIDTH  head entry, show-ahead.
REQ-013 out_ready  in  1  consumer accepts head.
REQ-014 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-015 almost_full, almost_empty  out  1 each  threshold flags.
REQ-016 ovf_err  out  1  sticky overflow flag (AXI_HS_FIFO_ERR_EN only).

Function
REQ-017 Push = in_valid && in_ready; pop = out_valid && out_ready; both may occur in one cycle.
REQ-018 in_ready = (count != DEPTH); out_valid = (count != 0); both combinational from registered count.
REQ-019 Push writes in_data at wptr; wptr advances; at DEPTH-1 wraps to 0 (explicit compare, not modulo 2^n).
REQ-020 Pop advances rptr with identical wrap rule.
REQ-021 out_data = mem[rptr] combinationally; undefined content when out_valid=0, must not be relied on.
REQ-022 count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-023 Full: in_ready=0, so in_valid with simultaneous pop is NOT accepted that cycle; accepted next cycle.
REQ-024 Empty: no bypass; word pushed into empty FIFO appears on out_valid/out_data the following cycle.
REQ-025 Write-to-read latency 1 cycle; throughput 1 word/cycle sustained when neither full nor empty.
REQ-026 almost_full, almost_empty combinational from count, AF_LEVEL/AE_LEVEL compared unsigned.
REQ-027 flush: next cycle wptr=rptr=count=0; flush overrides push/pop in same cycle (push dropped, pop ignored).
REQ-028 Storage array not reset; only pointers, count and flags reset.

Reset
REQ-029 reset asserted: wptr=0, rptr=0, count=0, ovf_err=0 immediately, independent of clk.
REQ-030 Resulting outputs: in_ready=1, out_valid=0, almost_empty=1, almost_full=(AF_LEVEL==0).
REQ-031 Reset mid-transfer discards all contents; first post-reset push is read first.

Configuration
REQ-032 Macro AXI_HS_FIFO_ERR_EN defined: ovf_err sets on any cycle with in_valid=1 and count==DEPTH, holds until reset or flush.
REQ-033 Macro undefined: ovf_err port present, tied to 0, no flag register inferred.

Structure
REQ-034 Package axi_fifo_pkg holds ptr_next function semantics-equivalent constants: default DEPTH, default WIDTH, and count-width helper via $clog2.
REQ-035 One sub-module axi_fifo_ptr: wrap-at-DEPTH pointer with inc and clr inputs, instantiated for wptr and rptr.
REQ-036 Elaboration check: AF_LEVEL <= DEPTH, AE_LEVEL < DEPTH, DEPTH >= 2; violation is a fatal error.

Verification (WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1)
REQ-037 Push 0x11..0x15 back-to-back -> count 1..5, almost_full at count 4, in_ready=0 after 5th; pops return 0x11..0x15 in order.
REQ-038 Fill to 5, drive in_valid+out_ready same cycle -> pop only, count 4, push accepted next cycle; ERR_EN build ovf_err=1.
REQ-039 Stream 12 words with continuous pop from empty -> pointers wrap 4->0 twice, data in order, count stays 1 after first cycle.
REQ-040 Push 0xA5 into empty -> out_valid=0 same cycle, out_valid=1 with out_data=0xA5 next cycle.
REQ-041 Load 3 words, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, ovf_err=0, pushed word absent.
REQ-042 Assert reset asynchronously mid-stream with count=3 -> count=0, in_ready=1, out_valid=0 before next clk edge.
